// File: rtl/calc_core.sv
// Multi-cycle arithmetic core: add, sub, iterative multiply, restoring divide and
// digit-by-digit integer square root behind a start/ready/done handshake.
module calc_core #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] opa,
    input  logic [DATA_WIDTH-1:0] opb,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  div_zero,
    output logic                  invalid
);

    localparam int unsigned W    = DATA_WIDTH;
    localparam int unsigned HW   = DATA_WIDTH / 2;
    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

    localparam logic [2:0] OpAdd  = 3'b000;
    localparam logic [2:0] OpSub  = 3'b001;
    localparam logic [2:0] OpMul  = 3'b010;
    localparam logic [2:0] OpDiv  = 3'b011;
    localparam logic [2:0] OpSqrt = 3'b100;

    if ((DATA_WIDTH % 2) != 0 || DATA_WIDTH < 4) begin : g_bad_width
        $error("calc_core: DATA_WIDTH must be even and at least 4");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q;
    logic [2:0]      op_q;
    logic [W-1:0]    a_q;     // mul: multiplicand, div: dividend/quotient, sqrt: radicand
    logic [W-1:0]    b_q;     // mul: multiplier, div: divisor
    logic [W-1:0]    acc_q;   // mul: product, div/sqrt: partial remainder
    logic [HW-1:0]   root_q;
    logic [CntW-1:0] cnt_q;

    // One iteration step of each iterative operation.
    logic [W-1:0]    mul_acc;
    logic [W:0]      div_shift;
    logic            div_ge;
    logic [W-1:0]    div_rem;
    logic [HW+1:0]   sq_shift;
    logic [HW+1:0]   sq_trial;
    logic            sq_ge;
    logic [HW+1:0]   sq_rem;
    logic [W-1:0]    final_res;
    logic [CntW-1:0] start_cnt;

    always_comb begin
        mul_acc   = acc_q + (b_q[0] ? a_q : '0);

        div_shift = {acc_q, a_q[W-1]};
        div_ge    = div_shift >= {1'b0, b_q};
        div_rem   = div_ge ? W'(div_shift - {1'b0, b_q}) : div_shift[W-1:0];

        // Remainder never exceeds 2*root, so HW bits of it survive the shift.
        sq_shift  = {acc_q[HW-1:0], a_q[W-1:W-2]};
        sq_trial  = {root_q, 2'b01};
        sq_ge     = sq_shift >= sq_trial;
        sq_rem    = sq_ge ? (sq_shift - sq_trial) : sq_shift;
    end

    always_comb begin
        final_res = '0;
        case (op_q)
            OpAdd:   final_res = a_q + b_q;
            OpSub:   final_res = a_q - b_q;
            OpMul:   final_res = acc_q;
            OpDiv:   final_res = (b_q == '0) ? '1 : a_q;
            OpSqrt:  final_res = W'(root_q);
            default: final_res = '0;
        endcase
    end

    always_comb begin
        start_cnt = '0;
        case (op)
            OpMul:   start_cnt = CntW'(W);
            OpDiv:   start_cnt = (opb == '0) ? '0 : CntW'(W);
            OpSqrt:  start_cnt = CntW'(HW);
            default: start_cnt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            root_q   <= '0;
            cnt_q    <= '0;
            ready    <= 1'b1;
            done     <= 1'b0;
            result   <= '0;
            div_zero <= 1'b0;
            invalid  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StRun;
                        ready   <= 1'b0;
                        op_q    <= op;
                        a_q     <= opa;
                        b_q     <= opb;
                        acc_q   <= '0;
                        root_q  <= '0;
                        cnt_q   <= start_cnt;
                    end
                end
                StRun: begin
                    if (cnt_q == '0) begin
                        state_q  <= StDone;
                        done     <= 1'b1;
                        result   <= final_res;
                        div_zero <= (op_q == OpDiv) && (b_q == '0);
                        invalid  <= op_q > OpSqrt;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                        case (op_q)
                            OpMul: begin
                                acc_q <= mul_acc;
                                a_q   <= a_q << 1;
                                b_q   <= b_q >> 1;
                            end
                            OpDiv: begin
                                acc_q <= div_rem;
                                a_q   <= {a_q[W-2:0], div_ge};
                            end
                            OpSqrt: begin
                                acc_q  <= W'(sq_rem);
                                a_q    <= a_q << 2;
                                root_q <= {root_q[HW-2:0], sq_ge};
                            end
                            default: ;
                        endcase
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done    <= 1'b0;
                    ready   <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    done    <= 1'b0;
                    ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_core.sv
// Scoreboard bench for calc_core: stimulus pushes expected responses, a monitor
// pops and checks result, flags and latency on every done pulse.
module tb_calc_core;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] opa = '0;
    logic [W-1:0] opb = '0;
    logic         ready;
    logic         done;
    logic [W-1:0] result;
    logic         div_zero;
    logic         invalid;

    calc_core #(.DATA_WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .opa      (opa),
        .opb      (opb),
        .ready    (ready),
        .done     (done),
        .result   (result),
        .div_zero (div_zero),
        .invalid  (invalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         dz;
        logic         inv;
        int           acc;
        int           lat;
        string        name;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] r, input logic dz, input logic inv,
                            input int acc, input int lat, input string nm);
        exp_t e;
        e.res = r; e.dz = dz; e.inv = inv; e.acc = acc; e.lat = lat; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic wait_ready();
        @(negedge clk);
        for (int i = 0; i < 100 && ready !== 1'b1; i++) @(negedge clk);
        if (ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_ready: ready=%b after 100 cycles, expected 1", ready);
        end
    endtask

    // Issue one operation, then scramble the inputs to show they are not re-sampled.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic edz, input logic einv,
                         input int lat, input string nm);
        wait_ready();
        start = 1'b1; op = o; opa = a; opb = b;
        @(posedge clk); #1;
        push_exp(er, edz, einv, cyc, lat, nm);
        start = 1'b0;
        op = 3'($urandom);
        opa = $urandom;
        opb = $urandom;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=1 with result=0x%08h, expected no done",
                             result);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_result"}, result, e.res);
                    check({e.name, "_div_zero"}, W'(div_zero), W'(e.dz));
                    check({e.name, "_invalid"}, W'(invalid), W'(e.inv));
                    check({e.name, "_latency"}, W'(cyc - e.acc), W'(e.lat));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        int acc;
        #12;
        check("reset_ready", W'(ready), 32'd1);
        check("reset_done", W'(done), 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_div_zero", W'(div_zero), 32'd0);
        check("reset_invalid", W'(invalid), 32'd0);
        @(negedge clk); rst = 1'b0;

        issue(3'b000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1, "add_5_7");
        issue(3'b001, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1, "sub_3_5");
        issue(3'b000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1, "add_wrap");
        issue(3'b010, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 1'b0, 33, "mul_ovf");
        issue(3'b010, 32'd1234, 32'd5678, 32'd7006652, 1'b0, 1'b0, 33, "mul_1234");
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 33, "mul_max");
        issue(3'b011, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33, "div_100_7");
        issue(3'b011, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1, "div_zero");
        issue(3'b011, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 33, "div_by_1");
        issue(3'b011, 32'd6, 32'd7, 32'd0, 1'b0, 1'b0, 33, "div_small");
        issue(3'b100, 32'd1000, 32'd0, 32'd31, 1'b0, 1'b0, 17, "isqrt_1000");
        issue(3'b100, 32'hFFFF_FFFF, 32'd5, 32'd65535, 1'b0, 1'b0, 17, "isqrt_max");
        issue(3'b100, 32'd0, 32'd9, 32'd0, 1'b0, 1'b0, 17, "isqrt_0");
        issue(3'b110, 32'd4, 32'd4, 32'd0, 1'b0, 1'b1, 1, "invalid_110");
        issue(3'b111, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 1, "invalid_111");

        // A start pulse mid-multiply must be dropped.
        issue(3'b010, 32'd1234, 32'd5678, 32'd7006652, 1'b0, 1'b0, 33, "mul_ignore");
        repeat (5) @(negedge clk);
        check("busy_ready", W'(ready), 32'd0);
        start = 1'b1; op = 3'b000; opa = 32'd1; opb = 32'd1;
        @(negedge clk);
        start = 1'b0;

        // Start held high: two adds, accepted three cycles apart.
        wait_ready();
        start = 1'b1; op = 3'b000; opa = 32'd10; opb = 32'd20;
        @(posedge clk); #1;
        acc = cyc;
        push_exp(32'd30, 1'b0, 1'b0, acc, 1, "b2b_first");
        push_exp(32'd30, 1'b0, 1'b0, acc + 3, 1, "b2b_second");
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;

        // Reset in the middle of a multiply.
        wait_ready();
        start = 1'b1; op = 3'b010; opa = 32'd1234; opb = 32'd5678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_ready", W'(ready), 32'd1);
        check("abort_done", W'(done), 32'd0);
        check("abort_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        issue(3'b000, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 1, "add_after_rst");

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", W'(sb.size()), 32'd0);
        check("final_result_held", result, 32'd4);
        check("final_ready", W'(ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calc_core.md
CALC_CORE -- requirements
Module: calc_core

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, operand/result width; SHALL be even and >= 4.
REQ-002 Port: clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: start  input  1  request; SHALL be accepted only on a rising edge where ready=1.
REQ-005 Port: op  input  3  operation: 000 add, 001 sub, 010 mul, 011 div, 100 isqrt, 101-111 invalid.
REQ-006 Port: opa  input  DATA_WIDTH  operand A, unsigned.
REQ-007 Port: opb  input  DATA_WIDTH  operand B, unsigned; ignored for isqrt.
REQ-008 Port: ready  output  1  block idle and able to accept start.
REQ-009 Port: done  output  1  single-cycle pulse; result and flags valid.
REQ-010 Port: result  output  DATA_WIDTH  operation result.
REQ-011 Port: div_zero  output  1  div with opb=0.
REQ-012 Port: invalid  output  1  op code 101-111.

Function
REQ-013 FSM states SHALL be IDLE, RUN, DONE; ready=1 only in IDLE.
REQ-014 IDLE->RUN on the accepting edge; op, opa and opb are latched on that edge, and later input changes SHALL have no effect.
REQ-015 RUN->DONE when the iteration counter expires; DONE->IDLE unconditionally after one cycle.
REQ-016 done=1 only in DONE; ready returns to 1 the cycle after done.
REQ-017 Latency, in cycles from the accepting edge to the first cycle with done=1: add/sub/invalid/div-by-zero 1; mul and div DATA_WIDTH+1; isqrt DATA_WIDTH/2+1.
REQ-018 add: result = (opa+opb) mod 2^DATA_WIDTH; carry discarded.
REQ-019 sub: result = (opa-opb) mod 2^DATA_WIDTH; two's-complement wrap.
REQ-020 mul: iterative shift-add, one bit per cycle; result = low DATA_WIDTH bits of opa*opb.
REQ-021 div: restoring, one quotient bit per cycle; result = floor(opa/opb); remainder discarded.
REQ-022 div with opb=0: no iteration; result all-ones, div_zero=1.
REQ-023 isqrt: digit-by-digit, two radicand bits per cycle; result = floor(sqrt(opa)), zero-extended.
REQ-024 invalid op: result 0, invalid=1, no iteration.
REQ-025 div_zero and invalid are 0 for all other operations; result and flags SHALL be updated only on entry to DONE and held until the next entry to DONE.
REQ-026 start while ready=0 (RUN or DONE) SHALL be ignored and not queued.
REQ-027 start held high continuously SHALL start a new operation on each IDLE edge, i.e. back-to-back with one idle cycle between done pulses.

Reset
REQ-028 While rst=1, regardless of clk: state=IDLE, ready=1, done=0, result=0, div_zero=0, invalid=0, counter and datapath registers cleared.
REQ-029 rst asserted mid-operation SHALL abort it; no done pulse follows, and previous result/flags are lost.
REQ-030 The first start accepted after rst deasserts SHALL behave identically to a start from power-up.

Verification (DATA_WIDTH=32)
REQ-031 add opa=5, opb=7 -> done 1 cycle after accept, result=12, flags 0; sub opa=3, opb=5 -> result=0xFFFFFFFE.
REQ-032 mul opa=0x00010000, opb=0x00010000 -> done at cycle 33, result=0; mul opa=1234, opb=5678 -> result=7006652.
REQ-033 div opa=100, opb=7 -> done at cycle 33, result=14; div opa=9, opb=0 -> done at cycle 1, result=0xFFFFFFFF, div_zero=1.
REQ-034 isqrt opa=1000 -> done at cycle 17, result=31; isqrt opa=0xFFFFFFFF -> result=65535.
REQ-035 op=110 -> done at cycle 1, result=0, invalid=1; a start pulse during a running mul is ignored, and that mul's result is unchanged.
REQ-036 rst pulse at cycle 10 of a mul -> no done pulse, ready=1 and result=0 immediately; a following add 2+2 -> result=4.
